seq_intt: RTL and testbench

SEQ_INTT -- requirements
Module: seq_intt

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/mod_mul.sv | 22 ++
 rtl/seq_intt.sv | 161 ++++++++++++++++
 tb/tb_seq_intt.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ntt_pkg -- shared NTT sizes, FSM state encoding and lane-slice helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
package ntt_pkg;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int LOG2N = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Bit offset of lane k in a packed vector of w-bit lanes.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod_mul -- combinational (a * b) mod m with a full 2W-bit product.
// Rev 1.0
// ----------------------------------------------------------------------------
module mod_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] p_o
);

  logic [2*W-1:0] prod;

  assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  // A zero modulus only occurs while reset has cleared the captured constants.
  assign p_o  = (m_i == '0) ? '0 : W'(prod % {{W{1'b0}}, m_i});

endmodule
`default_nettype wire

// File: rtl/seq_intt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_intt -- sequential direct-sum inverse NTT, one modular MAC per cycle.
// SEQ_INTT_SCALE_EN adds the per-output inv_n scaling state.  Rev 1.0
// ----------------------------------------------------------------------------
module seq_intt #(
  parameter int N = ntt_pkg::N,
  parameter int W = ntt_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] data_in,
  input  logic [W-1:0]   inv_omega,
  input  logic [W-1:0]   inv_n,
  input  logic [W-1:0]   mod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] data_out,
  output logic           busy
);

  import ntt_pkg::*;

  localparam int            LG   = $clog2(N);
  localparam logic [LG-1:0] LAST = LG'(N - 1);
  localparam logic [W-1:0]  ONE  = W'(1);

  state_e         state_q, state_d;
  logic [LG-1:0]  j_q, j_d, k_q, k_d;
  logic [W-1:0]   acc_q, acc_d, w_q, w_d, step_q, step_d;
  logic [W-1:0]   omega_q, omega_d, mod_q, mod_d;
  logic [N*W-1:0] x_q, x_d, out_q, out_d;

  logic [W-1:0]   x_k, prod_mac, w_next, step_next, acc_sum;
  logic [W:0]     sum_wide;

  assign x_k = x_q[lane_lsb(int'(k_q), W) +: W];

  mod_mul #(.W(W)) u_mac  (.a_i(x_k),    .b_i(w_q),     .m_i(mod_q), .p_o(prod_mac));
  mod_mul #(.W(W)) u_tw   (.a_i(w_q),    .b_i(step_q),  .m_i(mod_q), .p_o(w_next));
  mod_mul #(.W(W)) u_step (.a_i(step_q), .b_i(omega_q), .m_i(mod_q), .p_o(step_next));

  // Both addends are already < mod, so one conditional subtract reduces the sum.
  assign sum_wide = {1'b0, acc_q} + {1'b0, prod_mac};
  assign acc_sum  = (sum_wide >= {1'b0, mod_q}) ? W'(sum_wide - {1'b0, mod_q})
                                                : sum_wide[W-1:0];

`ifdef SEQ_INTT_SCALE_EN
  logic [W-1:0] invn_q, invn_d, scaled;
  mod_mul #(.W(W)) u_scale (.a_i(acc_q), .b_i(invn_q), .m_i(mod_q), .p_o(scaled));
`else
  logic unused_inv_n;
  assign unused_inv_n = ^inv_n;
`endif

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    w_d     = w_q;
    step_d  = step_q;
    omega_d = omega_q;
    mod_d   = mod_q;
    x_d     = x_q;
    out_d   = out_q;
`ifdef SEQ_INTT_SCALE_EN
    invn_d  = invn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = data_in;
          omega_d = inv_omega;
          mod_d   = mod;
`ifdef SEQ_INTT_SCALE_EN
          invn_d  = inv_n;
`endif
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          w_d     = ONE;
          step_d  = ONE;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_sum;
        w_d   = w_next;
        k_d   = k_q + LG'(1);
        if (k_q == LAST) begin
`ifdef SEQ_INTT_SCALE_EN
          state_d = S_SCALE;
`else
          out_d[lane_lsb(int'(j_q), W) +: W] = acc_sum;
          acc_d   = '0;
          w_d     = ONE;
          step_d  = step_next;
          j_d     = j_q + LG'(1);
          state_d = (j_q == LAST) ? S_DONE : S_ACC;
`endif
        end
      end
`ifdef SEQ_INTT_SCALE_EN
      S_SCALE: begin
        out_d[lane_lsb(int'(j_q), W) +: W] = scaled;
        acc_d   = '0;
        w_d     = ONE;
        step_d  = step_next;
        j_d     = j_q + LG'(1);
        state_d = (j_q == LAST) ? S_DONE : S_ACC;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      step_q  <= '0;
      omega_q <= '0;
      mod_q   <= '0;
      x_q     <= '0;
      out_q   <= '0;
`ifdef SEQ_INTT_SCALE_EN
      invn_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      step_q  <= step_d;
      omega_q <= omega_d;
      mod_q   <= mod_d;
      x_q     <= x_d;
      out_q   <= out_d;
`ifdef SEQ_INTT_SCALE_EN
      invn_q  <= invn_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign data_out  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_intt.sv
`default_nettype none
// tb_seq_intt -- randomized self-checking bench for seq_intt against a
// direct-sum transform model; honours SEQ_INTT_SCALE_EN like the design.
module tb_seq_intt;

  localparam int N = ntt_pkg::N;
  localparam int W = ntt_pkg::W;
`ifdef SEQ_INTT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  localparam int LAT = SCALE ? N * (N + 1) + 1 : N * N + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] data_in = '0;
  logic [W-1:0]   inv_omega = '0;
  logic [W-1:0]   inv_n = '0;
  logic [W-1:0]   mod = '0;
  logic           in_ready, out_valid, busy;
  logic [N*W-1:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_intt #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .inv_omega(inv_omega), .inv_n(inv_n), .mod(mod),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int powmod(input int b, input int e, input int m);
    int r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  // x_j = [inv_n *] sum_k X_k * om^(j*k) mod m, straight from the definition.
  function automatic logic [N*W-1:0] dft(input logic [N*W-1:0] x, input int om,
                                         input int invn, input int m, input bit scale);
    logic [N*W-1:0] y;
    y = '0;
    for (int j = 0; j < (1 << ntt_pkg::LOG2N); j++) begin
      int s;
      int xv;
      s = 0;
      for (int k = 0; k < N; k++) begin
        xv = x[ntt_pkg::lane_lsb(k, W) +: W];
        s  = (s + xv * powmod(om, j * k, m)) % m;
      end
      if (scale) s = (s * invn) % m;
      y[j*W +: W] = W'(s);
    end
    return y;
  endfunction

  task automatic scramble();
    in_valid = 1'($urandom);
    for (int k = 0; k < N; k++) data_in[k*W +: W] = W'($urandom);
    inv_omega = W'($urandom);
    inv_n     = W'($urandom);
    mod       = W'($urandom);
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic start_job(input logic [N*W-1:0] d, input logic [W-1:0] iw,
                           input logic [W-1:0] invn, input logic [W-1:0] m);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("start_ready", in_ready, 1);
    data_in = d; inv_omega = iw; inv_n = invn; mod = m; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance (cycle 0) to out_valid, scrambling inputs meanwhile.
  task automatic wait_done(output int lat, output logic [N*W-1:0] res);
    bit rdy_seen;
    bit busy_low;
    rdy_seen = 1'b0;
    busy_low = 1'b0;
    lat = -1;
    res = '0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(negedge clk);
      rdy_seen |= in_ready;
      busy_low |= !busy;
      if (out_valid) begin
        lat = c;
        res = data_out;
        break;
      end
      scramble();
    end
    in_valid = 1'b0;
    chk("job_in_ready_low", rdy_seen, 0);
    chk("job_busy_high", busy_low, 0);
    chk("latency", lat, LAT);
  endtask

  task automatic finish_job(input int stall, input logic [N*W-1:0] held);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_data", data_out, held);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [N*W-1:0] d, x, xf, res, exp_v;
    int lat;
    bit saw;

    // Reset state, then reset against a simultaneous input handshake.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);
    in_valid = 1'b1;
    data_in = 64'h0A0F0F0F0C04090C; inv_omega = 8'd2; inv_n = 8'd15; mod = 8'd17;
    @(negedge clk);
    chk("rst_dominates_in_ready", in_ready, 1);
    chk("rst_dominates_busy", busy, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // Known-answer vector, with a 20-cycle output stall.
    d = 64'h0A0F0F0F0C04090C;
    start_job(d, 8'd2, 8'd15, 8'd17);
    wait_done(lat, res);
    chk("kat_const", res, SCALE ? 64'h0000000006020103 : 64'h000000000E100807);
    chk("kat_model", res, dft(d, 2, 15, 17, SCALE));
    finish_job(20, res);

    // Reset at cycle 30 of a job aborts it with no out_valid pulse.
    start_job(d ^ 64'h0102030405060708, 8'd2, 8'd15, 8'd17);
    repeat (29) @(negedge clk);
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy_low", busy, 0);
    chk("abort_data_cleared", data_out, 0);
    saw = 1'b0;
    repeat (LAT + 10) begin
      @(negedge clk);
      saw |= out_valid;
    end
    chk("abort_no_out_valid", saw, 0);

    start_job(d, 8'd2, 8'd15, 8'd17);
    wait_done(lat, res);
    chk("after_abort_result", res, dft(d, 2, 15, 17, SCALE));
    finish_job(0, res);

    // Full-range lanes, arbitrary moduli and constants (lanes may exceed mod).
    for (int it = 0; it < 60; it++) begin
      logic [W-1:0] iw, invn, m;
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
      m    = W'($urandom_range(2, 255));
      iw   = W'($urandom);
      invn = W'($urandom);
      start_job(d, iw, invn, m);
      wait_done(lat, res);
      chk("rand_result", res, dft(d, int'(iw), int'(invn), int'(m), SCALE));
      finish_job($urandom_range(0, 3), res);
    end

    // Round trip: forward transform (omega 9, mod 17) in the bench, inverse in the DUT.
    for (int it = 0; it < 400; it++) begin
      for (int k = 0; k < N; k++) x[k*W +: W] = W'($urandom_range(0, 16));
      xf = dft(x, 9, 0, 17, 1'b0);
      for (int k = 0; k < N; k++)
        exp_v[k*W +: W] = SCALE ? x[k*W +: W] : W'((N * int'(x[k*W +: W])) % 17);
      start_job(xf, 8'd2, 8'd15, 8'd17);
      wait_done(lat, res);
      chk("round_trip", res, exp_v);
      finish_job($urandom_range(0, 2), res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
